// File: rtl/io_cell_cfg_pkg.sv
// Shared constants for the IO cell configuration register bank:
// register offsets, CTRL/STATUS bit positions and the apply-sequencer states.
package io_cell_cfg_pkg;

  localparam int unsigned CTRL_OFFSET   = 32'h000;
  localparam int unsigned STATUS_OFFSET = 32'h004;
  localparam int unsigned CELL_BASE     = 32'h040;
  localparam int unsigned ACTIVE_BASE   = 32'h100;

  localparam int CTRL_COMMIT_BIT    = 0;
  localparam int CTRL_LOCK_BIT      = 1;

  localparam int STATUS_BUSY_BIT    = 0;
  localparam int STATUS_LOCKED_BIT  = 1;
  localparam int STATUS_PENDING_BIT = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } apply_state_e;

endpackage

// File: rtl/io_cell_cfg_apply_seq.sv
// Apply sequencer: walks the cells one at a time after a commit, spacing the
// per-cell load strobes APPLY_GAP cycles apart so pad drivers do not all
// switch together.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no apply in progress; waits for an accepted commit
//   APPLY | walking cells; load cell idx whenever the gap counter is 0
module io_cell_cfg_apply_seq
  import io_cell_cfg_pkg::*;
#(
  parameter int NUM_CELLS = 10,
  parameter int APPLY_GAP = 4
) (
  input  logic                 clk_in,
  input  logic                 reset_int,
  input  logic                 start,
  output logic                 busy,
  output logic                 apply_done,
  output logic [NUM_CELLS-1:0] load
);

  localparam int IDX_W = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_CELLS - 1);
  localparam logic [7:0]       GAP_RELOAD = 8'(APPLY_GAP - 1);

  apply_state_e     state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       gap_q, gap_d;
  logic             done_d;
  logic             step;

  // State, cell index, gap counter and the registered done pulse.
  always_ff @(posedge clk_in or negedge reset_int) begin
    if (!reset_int) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      gap_q      <= '0;
      apply_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      apply_done <= done_d;
    end
  end

  // Next-state logic: a cell is loaded on every cycle the gap counter hits 0.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    done_d  = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = APPLY;
          idx_d   = '0;
          gap_d   = '0;
        end
      end
      APPLY: begin
        if (gap_q == 8'd0) begin
          step  = 1'b1;
          gap_d = GAP_RELOAD;
          idx_d = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar i = 0; i < NUM_CELLS; i++) begin : g_load
    assign load[i] = step && (idx_q == IDX_W'(i));
  end

  assign busy = (state_q == APPLY);

endmodule

// File: rtl/io_cell_cfg_regs.sv
// APB register bank for the IO cell frame configuration. Software writes the
// staged per-cell values, then commits; the apply sequencer copies them into
// the active cell_cfg vector one cell at a time. A sticky lock freezes all
// writes until reset.
module io_cell_cfg_regs
  import io_cell_cfg_pkg::*;
#(
  parameter int CONF_WIDTH = 5,
  parameter int NUM_CELLS  = 10,
  parameter int APB_AW     = 12,
  parameter int APPLY_GAP  = 4,
  parameter logic [NUM_CELLS*CONF_WIDTH-1:0] RESET_CFG = '0
) (
  input  logic                            clk_in,
  input  logic                            reset_int,
  input  logic                            psel,
  input  logic                            penable,
  input  logic                            pwrite,
  input  logic [APB_AW-1:0]               paddr,
  input  logic [31:0]                     pwdata,
  output logic [31:0]                     prdata,
  output logic                            pready,
  output logic                            pslverr,
  output logic [NUM_CELLS*CONF_WIDTH-1:0] cell_cfg,
  output logic                            apply_done
);

  localparam int CFG_W   = NUM_CELLS * CONF_WIDTH;
  localparam int CELL_AW = APB_AW - 2;

  logic [CFG_W-1:0]     staged_q;
  logic [CFG_W-1:0]     active_q;
  logic                 locked_q;
  logic                 busy;
  logic [NUM_CELLS-1:0] load;

  logic                 access;
  logic [APB_AW-1:0]    addr_a;
  logic [APB_AW-1:0]    cell_off;
  logic [APB_AW-1:0]    act_off;
  logic [CELL_AW-1:0]   cell_sel;
  logic [CELL_AW-1:0]   act_sel;
  logic                 is_ctrl, is_status, is_cell, is_active, mapped;
  logic                 err;
  logic                 wr_ok;
  logic                 commit;
  logic                 lock_set;
  logic                 cell_we;
  logic                 pending;
  logic [31:0]          rd_data;
  logic                 unused_bits;

  assign access   = psel & penable;
  assign addr_a   = {paddr[APB_AW-1:2], 2'b00};
  assign cell_off = addr_a - APB_AW'(CELL_BASE);
  assign act_off  = addr_a - APB_AW'(ACTIVE_BASE);
  assign cell_sel = cell_off[APB_AW-1:2];
  assign act_sel  = act_off[APB_AW-1:2];

  assign is_ctrl   = (addr_a == APB_AW'(CTRL_OFFSET));
  assign is_status = (addr_a == APB_AW'(STATUS_OFFSET));
  assign is_cell   = (addr_a >= APB_AW'(CELL_BASE)) &&
                     (cell_off < APB_AW'(4 * NUM_CELLS));
  assign is_active = (addr_a >= APB_AW'(ACTIVE_BASE)) &&
                     (act_off < APB_AW'(4 * NUM_CELLS));
  assign mapped    = is_ctrl | is_status | is_cell | is_active;

  assign pending = (staged_q != active_q);

  // Error decode: any rejected write is dropped entirely, including its
  // LOCK bit when a COMMIT in the same word is refused.
  always_comb begin
    err = 1'b0;
    if (access) begin
      if (!mapped) begin
        err = 1'b1;
      end else if (pwrite) begin
        if (is_status || is_active) begin
          err = 1'b1;
        end else if (locked_q) begin
          err = 1'b1;
        end else if (is_cell && busy) begin
          err = 1'b1;
        end else if (is_ctrl && pwdata[CTRL_COMMIT_BIT] && busy) begin
          err = 1'b1;
        end
      end
    end
  end

  assign wr_ok    = access & pwrite & ~err;
  assign commit   = wr_ok & is_ctrl & pwdata[CTRL_COMMIT_BIT];
  assign lock_set = wr_ok & is_ctrl & pwdata[CTRL_LOCK_BIT];
  assign cell_we  = wr_ok & is_cell;

  // Read mux; CTRL and unmapped addresses read as zero.
  always_comb begin
    rd_data = '0;
    if (is_status) begin
      rd_data[STATUS_BUSY_BIT]    = busy;
      rd_data[STATUS_LOCKED_BIT]  = locked_q;
      rd_data[STATUS_PENDING_BIT] = pending;
    end
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (is_cell && (cell_sel == CELL_AW'(i))) begin
        rd_data[CONF_WIDTH-1:0] = staged_q[i*CONF_WIDTH +: CONF_WIDTH];
      end
      if (is_active && (act_sel == CELL_AW'(i))) begin
        rd_data[CONF_WIDTH-1:0] = active_q[i*CONF_WIDTH +: CONF_WIDTH];
      end
    end
  end

  assign prdata  = access ? rd_data : 32'd0;
  assign pslverr = err;
  assign pready  = 1'b1;

  // Staged configuration written by software.
  always_ff @(posedge clk_in or negedge reset_int) begin
    if (!reset_int) begin
      staged_q <= RESET_CFG;
    end else begin
      for (int i = 0; i < NUM_CELLS; i++) begin
        if (cell_we && (cell_sel == CELL_AW'(i))) begin
          staged_q[i*CONF_WIDTH +: CONF_WIDTH] <= pwdata[CONF_WIDTH-1:0];
        end
      end
    end
  end

  // Active configuration, updated one cell per sequencer strobe.
  always_ff @(posedge clk_in or negedge reset_int) begin
    if (!reset_int) begin
      active_q <= RESET_CFG;
    end else begin
      for (int i = 0; i < NUM_CELLS; i++) begin
        if (load[i]) begin
          active_q[i*CONF_WIDTH +: CONF_WIDTH] <= staged_q[i*CONF_WIDTH +: CONF_WIDTH];
        end
      end
    end
  end

  // Sticky lock; only reset clears it.
  always_ff @(posedge clk_in or negedge reset_int) begin
    if (!reset_int) begin
      locked_q <= 1'b0;
    end else if (lock_set) begin
      locked_q <= 1'b1;
    end
  end

  io_cell_cfg_apply_seq #(
    .NUM_CELLS (NUM_CELLS),
    .APPLY_GAP (APPLY_GAP)
  ) u_apply_seq (
    .clk_in     (clk_in),
    .reset_int  (reset_int),
    .start      (commit),
    .busy       (busy),
    .apply_done (apply_done),
    .load       (load)
  );

  assign cell_cfg = active_q;

  assign unused_bits = ^{pwdata[31:CONF_WIDTH], paddr[1:0]};

endmodule

// File: doc/io_cell_cfg_regs.md
Name: io_cell_cfg_regs

Overview:
- APB-slave register bank that produces the packed `cell_cfg` vector consumed by the SoC IO cell frame.
- Software writes per-cell configuration into staged registers, then commits them.
- A sequencer copies the staged values to the active outputs one cell at a time, with a programmable gap between cells, to limit simultaneous pad-driver switching.
- A sticky lock freezes the configuration until reset.

Parameters:
- CONF_WIDTH, 5, config bits per IO cell.
- NUM_CELLS, 10, number of cells; `cell_cfg` width = NUM_CELLS*CONF_WIDTH.
- APB_AW, 12, APB address width.
- APPLY_GAP, 4, clock cycles between successive cell updates during apply; legal range 1..255.
- RESET_CFG, all zeros, NUM_CELLS*CONF_WIDTH reset/default value of both staged and active configuration.

Ports:
- clk_in  input  1  system clock; the block's only clock.
- reset_int  input  1  asynchronous, active-low reset.
- psel  input  1  APB select.
- penable  input  1  APB enable.
- pwrite  input  1  APB write.
- paddr  input  APB_AW  APB byte address; word-aligned, bits[1:0] ignored.
- pwdata  input  32  APB write data.
- prdata  output  32  APB read data.
- pready  output  1  tied to 1; zero-wait-state slave.
- pslverr  output  1  APB error, valid in the access phase.
- cell_cfg  output  NUM_CELLS*CONF_WIDTH  active configuration; cell i occupies bits [(i+1)*CONF_WIDTH-1 : i*CONF_WIDTH].
- apply_done  output  1  one-cycle pulse after the last cell has been applied.

Behaviour:

Register map (32-bit words):
- 0x000 CTRL, write-only:
  - bit0 COMMIT: write 1 to start apply.
  - bit1 LOCK: write 1 to set the sticky lock.
  - Reads return 0.
- 0x004 STATUS, read-only:
  - bit0 busy.
  - bit1 locked.
  - bit2 pending (staged != active).
- 0x040+4*i CELL_i staged, R/W, bits[CONF_WIDTH-1:0]; upper bits are written as ignored and read as 0.
- 0x100+4*i ACTIVE_i, read-only mirror of `cell_cfg` slice i.

APB access:
- Access occurs when psel & penable; all effects are taken at that edge.
- `prdata` is combinational from the address during the access phase; 0 otherwise.

`pslverr`=1 (write dropped) for:
- unmapped address, or i >= NUM_CELLS;
- write to STATUS or ACTIVE;
- any write while locked, including CTRL;
- a CELL write while busy;
- COMMIT while busy.
- Reads of mapped addresses never error.

Reset (reset_int low, asynchronous):
- staged = active = RESET_CFG.
- busy = 0, locked = 0.
- apply_done = 0, prdata = 0, pslverr = 0.
- Sequencer returns to IDLE.
- Reset asserted mid-apply aborts the apply; no partial state survives.

Apply sequencer:
- States: IDLE, APPLY.
- IDLE -> APPLY on an accepted COMMIT write at edge T. At that edge: idx=0, gap counter=0, busy=1 from T+1.
- In APPLY, on each edge with gap counter==0:
  - active[idx] <= staged[idx];
  - gap counter <= APPLY_GAP-1;
  - idx++.
- Otherwise the gap counter decrements.
- Cell i therefore changes at edge T+1+i*APPLY_GAP.
- On the edge applying cell NUM_CELLS-1: state -> IDLE, busy -> 0, and `apply_done` is high for exactly the following cycle.
- A COMMIT with staged == active still walks all cells, with identical timing, and pulses `apply_done`.
- COMMIT and LOCK in the same write: the commit is accepted and the lock sets at the same edge. The apply completes normally while locked.
- LOCK while busy is accepted; the apply completes.

Widths and status:
- `idx` is $clog2(NUM_CELLS) bits; the gap counter is 8 bits.
- pending is the combinational compare of the full staged and active vectors.

Decomposition:
- Package io_cell_cfg_pkg:
  - address offset constants (CTRL, STATUS, CELL_BASE, ACTIVE_BASE);
  - CTRL/STATUS bit indices;
  - apply-state enum (IDLE, APPLY).
- Sub-module io_cell_cfg_apply_seq: state, idx, gap counter, busy, apply_done; outputs a per-cell load strobe.
- The top level contains APB decode, staged/active storage and error logic.

Test Plan:
- Reset with RESET_CFG=0 -> `cell_cfg`=0, STATUS reads 0x0, `apply_done`=0; read CELL_3 -> 0, pslverr=0.
- Write CELL_0=0x15 and CELL_9=0x0A, STATUS -> 0x4; COMMIT at edge T with APPLY_GAP=4 -> `cell_cfg`[4:0]=0x15 after T+1; `cell_cfg`[49:45]=0x0A after T+37; busy deasserts then; `apply_done` is high in cycle T+38 only; STATUS -> 0x0.
- During busy: write CELL_2 -> pslverr=1, staged unchanged; second COMMIT -> pslverr=1, timing unaffected.
- Write CTRL=0x3 -> apply runs to completion and locked=1; then write CELL_1 -> pslverr=1; write CTRL=0x1 -> pslverr=1 and no apply; STATUS -> 0x2.
- Access 0x068 (cell 10, out of range) and write 0x004 -> pslverr=1 for both; read 0x068 -> pslverr=1, prdata=0.
- Assert reset_int low at edge T+9 of an apply -> `cell_cfg`=RESET_CFG immediately, busy=0, locked=0; after release, COMMIT with no new writes -> full walk, `apply_done` pulses.
